mapper_zemina90_bankreg: RTL and testbench

//  Write-side companion of the Zemina 90-in-1 ROM mapper. Captures CPU I/O

---
 rtl/mapper_zemina90_bankreg_if.sv | 33 +++
 rtl/mapper_zemina90_bankreg.sv | 94 +++++++++
 tb/tb_mapper_zemina90_bankreg.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mapper_zemina90_bankreg_if.sv
// Bus bundle between the CPU-side decode and the Zemina 90-in-1 bank register.
// Signals:
//   iorq, wr, rd     CPU I/O request and strobes
//   io_addr          CPU address[7:0] during an I/O cycle
//   data_in          CPU write data
//   mem_addr         CPU memory address for the current access
//   data_to_mapper   8KB segment number for mem_addr (0xFF outside the window)
//   window_hit       mem_addr falls in 0x4000-0xBFFF
//   io_dout          bank register readback (0xFF when not selected)
//   io_dout_en       readback valid
// Modports: master = CPU/bus side, slave = bank register.
interface mapper_zemina90_bankreg_if;
    logic        iorq;
    logic        wr;
    logic        rd;
    logic [7:0]  io_addr;
    logic [7:0]  data_in;
    logic [15:0] mem_addr;
    logic [7:0]  data_to_mapper;
    logic        window_hit;
    logic [7:0]  io_dout;
    logic        io_dout_en;

    modport master (
        output iorq, wr, rd, io_addr, data_in, mem_addr,
        input  data_to_mapper, window_hit, io_dout, io_dout_en
    );

    modport slave (
        input  iorq, wr, rd, io_addr, data_in, mem_addr,
        output data_to_mapper, window_hit, io_dout, io_dout_en
    );
endinterface

// File: rtl/mapper_zemina90_bankreg.sv
// Zemina 90-in-1 bank register: captures CPU I/O writes to the bank port,
// returns the register on reads of that port, and decodes the 8KB segment
// number for memory accesses in 0x4000-0xBFFF.
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   enable   cartridge slot configured as Zemina 90
//   bus      CPU-side bundle (slave modport): strobes, addresses, data,
//            segment output and readback
//   bank     current bank register
//   bank_wr  one-cycle pulse, high in the cycle the new bank value is visible
module mapper_zemina90_bankreg #(
    parameter logic [7:0] PORT_ADDR  = 8'h77,
    parameter logic [7:0] RESET_BANK = 8'h00
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            enable,
    mapper_zemina90_bankreg_if.slave        bus,
    output logic [7:0]                      bank,
    output logic                            bank_wr
);

    logic       port_sel;
    logic       wstb;
    logic       strobe_q;
    logic       bank_wr_q;
    logic [7:0] bank_q;
    logic       wr_edge;

    assign port_sel = enable && bus.iorq && (bus.io_addr == PORT_ADDR);
    assign wstb     = port_sel && bus.wr;
    assign wr_edge  = wstb && !strobe_q;

    // strobe_q resets high so a strobe already asserted when reset releases
    // must drop and rise again before it writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            strobe_q  <= 1'b1;
            bank_q    <= RESET_BANK;
            bank_wr_q <= 1'b0;
        end else begin
            strobe_q  <= wstb;
            bank_wr_q <= wr_edge;
            if (wr_edge) begin
                bank_q <= bus.data_in;
            end
        end
    end

    assign bank    = bank_q;
    assign bank_wr = bank_wr_q;

    // Readback shows the current (pre-write) register value.
    assign bus.io_dout_en = port_sel && bus.rd;
    assign bus.io_dout    = bus.io_dout_en ? bank_q : 8'hFF;

    // Segment decode.
    logic [2:0] region;
    logic [1:0] mode;
    logic [7:0] base16;
    logic [7:0] base32;
    logic [7:0] seg;

    assign region         = bus.mem_addr[15:13];
    assign mode           = bank_q[7:6];
    assign bus.window_hit = (region >= 3'd2) && (region <= 3'd5);
    assign base16         = {1'b0, bank_q[5:0], 1'b0};
    assign base32         = {1'b0, bank_q[5:1], 2'b00};

    always_comb begin
        seg = 8'hFF;
        if (!mode[1]) begin
            // 16KB modes: same 16KB block mirrored into 4000-7FFF and 8000-BFFF.
            unique case (region)
                3'd2, 3'd4: seg = base16;
                3'd3, 3'd5: seg = base16 + 8'd1;
                default:    seg = 8'hFF;
            endcase
        end else begin
            // 32KB modes; mode 11 swaps the upper pair of pages.
            unique case (region)
                3'd2:    seg = base32;
                3'd3:    seg = base32 + 8'd1;
                3'd4:    seg = mode[0] ? base32 + 8'd3 : base32 + 8'd2;
                3'd5:    seg = mode[0] ? base32 + 8'd2 : base32 + 8'd3;
                default: seg = 8'hFF;
            endcase
        end
    end

    assign bus.data_to_mapper = (enable && bus.window_hit) ? seg : 8'hFF;

endmodule

// File: tb/tb_mapper_zemina90_bankreg.sv
module tb_mapper_zemina90_bankreg;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b1;
    logic [7:0] bank;
    logic       bank_wr;

    int total = 0;
    int bad = 0;
    int pulses = 0;
    bit cmp_on = 1'b0;

    mapper_zemina90_bankreg_if bus ();

    mapper_zemina90_bankreg dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .bus     (bus),
        .bank    (bank),
        .bank_wr (bank_wr)
    );

    always #5 clk = ~clk;

    // Reference model: bank value, whether a strobe has already been consumed,
    // and whether the last clock performed a write.
    logic [7:0] m_bank = 8'h00;
    bit         m_used = 1'b1;
    bit         m_wrote = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_bank  = 8'h00;
            m_used  = 1'b1;
            m_wrote = 1'b0;
        end else begin
            bit strobe;
            strobe  = enable && bus.iorq && bus.wr && (bus.io_addr == 8'h77);
            m_wrote = strobe && !m_used;
            if (m_wrote) m_bank = bus.data_in;
            m_used  = strobe;
        end
    end

    function automatic logic [7:0] model_seg(logic [7:0] b, logic [15:0] a, logic en);
        int r;
        int idx;
        int s;
        r = int'(a[15:13]);
        if (!en || r < 2 || r > 5) return 8'hFF;
        idx = r - 2;
        if (!b[7]) begin
            s = int'(b[5:0]) * 2 + (idx % 2);
        end else begin
            if (b[6] && idx >= 2) idx = 5 - idx;
            s = (int'(b[5:0]) / 2) * 4 + idx;
        end
        return s[7:0];
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            logic       en_exp;
            logic [2:0] r;
            r      = bus.mem_addr[15:13];
            en_exp = enable && bus.iorq && bus.rd && (bus.io_addr == 8'h77);
            chk("model bank", {8'h0, bank}, {8'h0, m_bank});
            chk("model bank_wr", {15'h0, bank_wr}, {15'h0, m_wrote});
            chk("model window_hit", {15'h0, bus.window_hit}, {15'h0, (r >= 2 && r <= 5)});
            chk("model dtm", {8'h0, bus.data_to_mapper},
                {8'h0, model_seg(m_bank, bus.mem_addr, enable)});
            chk("model io_dout_en", {15'h0, bus.io_dout_en}, {15'h0, en_exp});
            chk("model io_dout", {8'h0, bus.io_dout}, {8'h0, en_exp ? m_bank : 8'hFF});
        end
        if (bank_wr === 1'b1) pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.iorq = 1'b0;
        bus.wr   = 1'b0;
        bus.rd   = 1'b0;
    endtask

    task automatic io_write(input logic [7:0] addr, input logic [7:0] data, input int len);
        bus.iorq    = 1'b1;
        bus.wr      = 1'b1;
        bus.io_addr = addr;
        bus.data_in = data;
        repeat (len) tick();
        idle();
        tick();
    endtask

    task automatic seg4(input string name, input logic [7:0] e0, input logic [7:0] e1,
                        input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0]  exp [4];
        logic [15:0] addrs [4];
        exp   = '{e0, e1, e2, e3};
        addrs = '{16'h4000, 16'h6000, 16'h8000, 16'hA000};
        for (int i = 0; i < 4; i++) begin
            bus.mem_addr = addrs[i];
            #1;
            chk(name, {8'h0, bus.data_to_mapper}, {8'h0, exp[i]});
        end
    endtask

    initial begin
        int p0;
        idle();
        bus.io_addr  = 8'h00;
        bus.data_in  = 8'h00;
        bus.mem_addr = 16'h4000;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        cmp_on = 1'b1;

        // 1: reset state
        chk("reset bank", {8'h0, bank}, 16'h0000);
        chk("reset bank_wr", {15'h0, bank_wr}, 16'h0000);
        chk("reset dtm 4000", {8'h0, bus.data_to_mapper}, 16'h0000);
        bus.mem_addr = 16'h0000;
        #1;
        chk("reset dtm 0000", {8'h0, bus.data_to_mapper}, 16'h00FF);
        chk("reset window_hit", {15'h0, bus.window_hit}, 16'h0000);
        tick();

        // 2: long strobe writes once
        p0 = pulses;
        io_write(8'h77, 8'h05, 4);
        tick();
        chk("wr05 pulses", pulses[15:0], p0[15:0] + 16'd1);
        chk("wr05 bank", {8'h0, bank}, 16'h0005);
        seg4("bank05 seg", 8'h0A, 8'h0B, 8'h0A, 8'h0B);
        bus.mem_addr = 16'hC000;
        #1;
        chk("bank05 C000", {8'h0, bus.data_to_mapper}, 16'h00FF);

        // 3: 32KB modes
        io_write(8'h77, 8'h85, 1);
        chk("wr85 bank", {8'h0, bank}, 16'h0085);
        seg4("bank85 seg", 8'h08, 8'h09, 8'h0A, 8'h0B);
        io_write(8'h77, 8'hC5, 2);
        seg4("bankC5 seg", 8'h08, 8'h09, 8'h0B, 8'h0A);

        // 4: ignored writes and readback
        p0 = pulses;
        io_write(8'h76, 8'h11, 2);
        enable = 1'b0;
        io_write(8'h77, 8'h22, 2);
        bus.mem_addr = 16'h4000;
        #1;
        chk("disabled dtm", {8'h0, bus.data_to_mapper}, 16'h00FF);
        enable = 1'b1;
        tick();
        chk("ignored bank", {8'h0, bank}, 16'h00C5);
        chk("ignored pulses", pulses[15:0], p0[15:0]);
        bus.iorq = 1'b1;
        bus.rd = 1'b1;
        bus.io_addr = 8'h77;
        #1;
        chk("rd77 dout", {8'h0, bus.io_dout}, 16'h00C5);
        chk("rd77 en", {15'h0, bus.io_dout_en}, 16'h0001);
        bus.io_addr = 8'h76;
        #1;
        chk("rd76 dout", {8'h0, bus.io_dout}, 16'h00FF);
        chk("rd76 en", {15'h0, bus.io_dout_en}, 16'h0000);
        // simultaneous rd and wr: old value read, write taken
        bus.io_addr = 8'h77;
        bus.wr = 1'b1;
        bus.data_in = 8'h44;
        #1;
        chk("rdwr old", {8'h0, bus.io_dout}, 16'h00C5);
        tick();
        idle();
        chk("rdwr new bank", {8'h0, bank}, 16'h0044);
        tick();

        // 5: reset mid-strobe
        bus.iorq = 1'b1;
        bus.wr = 1'b1;
        bus.io_addr = 8'h77;
        bus.data_in = 8'h33;
        tick();
        tick();
        chk("pre-reset bank", {8'h0, bank}, 16'h0033);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        p0 = pulses;
        repeat (3) tick();
        chk("held strobe bank", {8'h0, bank}, 16'h0000);
        chk("held strobe pulses", pulses[15:0], p0[15:0]);
        idle();
        tick();
        bus.iorq = 1'b1;
        bus.wr = 1'b1;
        tick();
        idle();
        tick();
        chk("rearm bank", {8'h0, bank}, 16'h0033);
        chk("rearm pulses", pulses[15:0], p0[15:0] + 16'd1);

        // 6: back-to-back writes
        p0 = pulses;
        io_write(8'h77, 8'h3F, 1);
        seg4("bank3F seg", 8'h7E, 8'h7F, 8'h7E, 8'h7F);
        io_write(8'h77, 8'hFF, 1);
        tick();
        chk("b2b pulses", pulses[15:0], p0[15:0] + 16'd2);
        chk("b2b bank", {8'h0, bank}, 16'h00FF);
        seg4("bankFF seg", 8'h7C, 8'h7D, 8'h7F, 8'h7E);
        tick();

        cmp_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
